rgb_fade_pwm: RTL and testbench

Upstream feeder for the iCE40 SB_RGBA_DRV LED driver.
- Accepts a target RGB colour via a valid/ready command handshake.
- Linearly ramps three internal intensity levels toward the target, one LSB per fade step.
- Emits three glitch-free, registered PWM bits wired directly to the driver's RGBxPWM inputs.
- Replaces free-running breathing generators when firmware-controlled colour fades are needed.

---
 rtl/rgb_fade_pkg.sv | 15 +
 rtl/rgb_fade_channel.sv | 59 +++++
 rtl/rgb_fade_pwm.sv | 113 +++++++++++
 tb/tb_rgb_fade_pwm.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fade_pkg.sv
// Shared constants for the RGB fade/PWM feeder.
// Channel indices follow the SB_RGBA_DRV RGB0/1/2 pin order.
package rgb_fade_pkg;

   localparam int CH_BLUE  = 0;
   localparam int CH_RED   = 1;
   localparam int CH_GREEN = 2;
   localparam int NUM_CH   = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FADE = 1'b1
   } state_e;

endpackage

// File: rtl/rgb_fade_channel.sv
// One colour channel: target, saturating level ramp,
// period-aligned shadow duty and registered PWM compare.
module rgb_fade_channel
   import rgb_fade_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] target,
   input  logic             tick,
   input  logic             wrap,
   input  logic [WIDTH-1:0] pwm_cnt,
   output logic [WIDTH-1:0] level,
   output logic             at_target,
   output logic             pwm
);

   logic [WIDTH-1:0] target_q;
   logic [WIDTH-1:0] level_q, level_d;
   logic [WIDTH-1:0] shadow_q;
   logic             pwm_q;

   always_comb begin
      level_d = level_q;
      if (tick) begin
         if (level_q < target_q) begin
            level_d = level_q + 1'b1;
         end else if (level_q > target_q) begin
            level_d = level_q - 1'b1;
         end
      end
   end

   // Shadow only reloads on the last count so periods stay whole.
   always_ff @(posedge clk) begin
      if (rst) begin
         target_q <= '0;
         level_q  <= '0;
         shadow_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         if (load) begin
            target_q <= target;
         end
         level_q <= level_d;
         if (wrap) begin
            shadow_q <= level_q;
         end
         pwm_q <= (pwm_cnt < shadow_q);
      end
   end

   assign level     = level_q;
   assign at_target = (level_q == target_q);
   assign pwm       = pwm_q;

endmodule

// File: rtl/rgb_fade_pwm.sv
// RGB fade controller feeding SB_RGBA_DRV PWM inputs:
// command handshake, fade FSM, step prescaler and PWM counter.
module rgb_fade_pwm
   import rgb_fade_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int STEP_DIV = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_red,
   input  logic [WIDTH-1:0] cmd_green,
   input  logic [WIDTH-1:0] cmd_blue,
   output logic             busy,
   output logic             done,
   output logic [2:0]       pwm
);

   localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(STEP_DIV - 1);

   state_e           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] cnt_q;
   logic             accept;
   logic             tick;
   logic             wrap;
   logic             all_at;

   logic [NUM_CH-1:0]            at_target;
   logic [NUM_CH-1:0][WIDTH-1:0] target;
   logic [NUM_CH-1:0][WIDTH-1:0] level;

   assign target[CH_BLUE]  = cmd_blue;
   assign target[CH_RED]   = cmd_red;
   assign target[CH_GREEN] = cmd_green;

   assign all_at = &at_target;
   assign wrap   = &cnt_q;
   assign tick   = (state_q == ST_FADE) && (presc_q == PRE_MAX);

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               accept  = 1'b1;
               state_d = ST_FADE;
            end
         end
         ST_FADE: begin
            busy = 1'b1;
            // Equality is checked before stepping, so a no-op
            // command completes on the very next cycle.
            if (all_at) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      presc_d = presc_q + 1'b1;
      if (accept || presc_q == PRE_MAX) begin
         presc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_q + 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      rgb_fade_channel #(
         .WIDTH(WIDTH)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .load     (accept),
         .target   (target[i]),
         .tick     (tick),
         .wrap     (wrap),
         .pwm_cnt  (cnt_q),
         .level    (level[i]),
         .at_target(at_target[i]),
         .pwm      (pwm[i])
      );
   end

   // Levels may only move on a fade step.
   a_level_hold : assert property (
      @(posedge clk) disable iff (rst)
      !tick |=> $stable(level)
   );

endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Randomised bench for rgb_fade_pwm against a time-based
// reference model (WIDTH = 4, STEP_DIV = 4).
module tb_rgb_fade_pwm;

   localparam int W  = 4;
   localparam int SD = 4;
   localparam int P  = 1 << W;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic [W-1:0] cmd_red = '0;
   logic [W-1:0] cmd_green = '0;
   logic [W-1:0] cmd_blue = '0;
   logic         cmd_ready;
   logic         busy;
   logic         done;
   logic [2:0]   pwm;

   always #5 clk = ~clk;

   rgb_fade_pwm #(
      .WIDTH   (W),
      .STEP_DIV(SD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_red  (cmd_red),
      .cmd_green(cmd_green),
      .cmd_blue (cmd_blue),
      .busy     (busy),
      .done     (done),
      .pwm      (pwm)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   // Reference model: levels are a closed-form function of the
   // time since acceptance; done time is predicted up front.
   int   ncyc = 0;
   int   m_cnt = 0;
   int   m_busy = 0;
   int   acc = 0;
   int   done_at = -1;
   int   done_seen = 0;
   int   m_lvl[3] = '{0, 0, 0};
   int   m_start[3] = '{0, 0, 0};
   int   m_tgt[3] = '{0, 0, 0};
   int   m_shadow[3] = '{0, 0, 0};
   logic [2:0] m_pwm = '0;

   function automatic int cmd_ch(input int i);
      case (i)
         0:       return int'(cmd_blue);
         1:       return int'(cmd_red);
         default: return int'(cmd_green);
      endcase
   endfunction

   task automatic model_step();
      int old_lvl[3];
      int d, md, e, t;
      ncyc++;
      if (rst) begin
         m_cnt = 0;
         m_busy = 0;
         done_at = -1;
         m_pwm = '0;
         for (int i = 0; i < 3; i++) begin
            m_lvl[i] = 0;
            m_start[i] = 0;
            m_tgt[i] = 0;
            m_shadow[i] = 0;
         end
         return;
      end
      for (int i = 0; i < 3; i++) begin
         m_pwm[i] = (m_cnt < m_shadow[i]);
         old_lvl[i] = m_lvl[i];
      end
      if (m_cnt == P - 1) begin
         for (int i = 0; i < 3; i++) m_shadow[i] = old_lvl[i];
      end
      m_cnt = (m_cnt + 1) % P;
      if (!m_busy && cmd_valid) begin
         acc = ncyc - 1;
         md = 0;
         for (int i = 0; i < 3; i++) begin
            m_start[i] = m_lvl[i];
            m_tgt[i] = cmd_ch(i);
            d = m_tgt[i] - m_start[i];
            if (d < 0) d = -d;
            if (d > md) md = d;
         end
         done_at = acc + 1 + md * SD;
         m_busy = 1;
      end else if (m_busy && ncyc - 1 == done_at) begin
         m_busy = 0;
      end
      if (m_busy) begin
         e = ncyc - acc;
         t = (e >= 1) ? (e - 1) / SD : 0;
         for (int i = 0; i < 3; i++) begin
            d = m_tgt[i] - m_start[i];
            if (d >= 0) m_lvl[i] = m_start[i] + ((d < t) ? d : t);
            else m_lvl[i] = m_start[i] - ((-d < t) ? -d : t);
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("ready", cmd_ready, !m_busy);
      check("busy", busy, m_busy);
      check("done", done, (m_busy != 0) && (ncyc == done_at));
      check("pwm", pwm, m_pwm);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("lvl%0d", i), dut.level[i], m_lvl[i]);
      end
      if (done) done_seen++;
   endtask

   task automatic send(input int r, input int g, input int b);
      cmd_red = W'(r);
      cmd_green = W'(g);
      cmd_blue = W'(b);
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int k = 0;
      while (m_busy && k < max) begin
         cyc();
         k++;
      end
      check("idle_timeout", busy, 0);
   endtask

   int d0;

   initial begin
      rst = 1'b1;
      repeat (3) cyc();
      rst = 1'b0;
      repeat (64) cyc();

      d0 = done_seen;
      send(3, 0, 15);
      wait_idle(200);
      check("done_cnt_up", done_seen - d0, 1);
      repeat (48) cyc();

      d0 = done_seen;
      send(0, 8, 15);
      wait_idle(200);
      check("done_cnt_down", done_seen - d0, 1);
      repeat (20) cyc();

      cmd_red = 4'd15;
      cmd_green = 4'd15;
      cmd_blue = 4'd0;
      cmd_valid = 1'b1;
      cyc();
      for (int k = 0; k < 20; k++) begin
         cmd_red = W'($urandom);
         cmd_green = W'($urandom);
         cmd_blue = W'($urandom);
         cyc();
      end
      cmd_valid = 1'b0;
      wait_idle(200);
      check("held_tgt_r", dut.level[1], 15);
      check("held_tgt_b", dut.level[0], 0);

      d0 = done_seen;
      send(m_lvl[1], m_lvl[2], m_lvl[0]);
      cyc();
      check("equal_done", done_seen - d0, 1);
      wait_idle(10);

      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      send(15, 15, 15);
      repeat (4 * 5 - 1) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rst_pwm", pwm, 0);
      d0 = done_seen;
      repeat (40) cyc();
      check("rst_no_done", done_seen - d0, 0);
      send(2, 9, 5);
      wait_idle(200);

      for (int it = 0; it < 25; it++) begin
         cmd_red = W'($urandom);
         cmd_green = W'($urandom);
         cmd_blue = W'($urandom);
         cmd_valid = 1'b1;
         cyc();
         for (int k = 0; k < int'($urandom_range(0, 10)); k++) begin
            cmd_valid = 1'($urandom);
            cmd_red = W'($urandom);
            cmd_green = W'($urandom);
            cmd_blue = W'($urandom);
            cyc();
         end
         cmd_valid = 1'b0;
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(0, 30)) cyc();
            rst = 1'b1;
            cyc();
            rst = 1'b0;
         end
         wait_idle(200);
         repeat ($urandom_range(0, 40)) cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
